shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Command-driven one-hot pattern sequencer with prescaler and bounce/rotate/hold modes.
// Optional build macro SHIFT_SEQ_ONESHOT_EN enables auto-stop after one full pattern period.
module shift_sequencer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DIV_W-1:0] cmd_data,
  output logic [7:0]       pattern,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_APPLY} state_t;
  typedef enum logic [1:0] {OP_RUN, OP_STOP, OP_SET_MODE, OP_SET_DIV} op_t;
  typedef enum logic [1:0] {M_BOUNCE, M_ROT_L, M_ROT_R, M_HOLD} mode_t;

  state_t           r_state, w_state_nxt;
  mode_t            r_mode, w_mode_nxt;
  logic             r_run, w_run_nxt;
  logic             r_oneshot, w_oneshot_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_pattern, w_pat_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_step, w_step_nxt;
  logic             r_wrap, w_wrap_nxt;

  logic       w_accept, w_tick;
  logic [7:0] w_rotl, w_rotr;

  // cmd_ready drops with reset itself so nothing is accepted while reset is asserted.
  assign cmd_ready = reset && (r_state != S_APPLY);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_tick    = (r_state == S_RUN) && (r_cnt == r_div);
  assign w_rotl    = {r_pattern[6:0], r_pattern[7]};
  assign w_rotr    = {r_pattern[0], r_pattern[7:1]};

  always_comb begin
    // NOTE: every next-state value gets a default first so no path through this block infers a latch.
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_run_nxt     = r_run;
    w_oneshot_nxt = r_oneshot;
    w_div_nxt     = r_div;
    w_cnt_nxt     = r_cnt;
    w_pat_nxt     = r_pattern;
    w_dir_nxt     = r_dir;
    w_step_nxt    = 1'b0;
    w_wrap_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_APPLY;
      S_RUN:   if (w_accept) w_state_nxt = S_APPLY;
      S_APPLY: w_state_nxt = r_run ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // A command accepted in a tick cycle takes priority and the pattern update is dropped.
    if (w_accept) begin
      w_cnt_nxt = '0;
      unique case (op_t'(cmd_op))
        OP_RUN:  w_run_nxt = 1'b1;
        OP_STOP: w_run_nxt = 1'b0;
        OP_SET_MODE: begin
          w_mode_nxt = mode_t'(cmd_data[1:0]);
`ifdef SHIFT_SEQ_ONESHOT_EN
          w_oneshot_nxt = cmd_data[2];
`else
          w_oneshot_nxt = 1'b0;
`endif
          w_pat_nxt  = 8'h01;
          w_dir_nxt  = 1'b0;
        end
        OP_SET_DIV: w_div_nxt = cmd_data;
        default: ;
      endcase
    end else if (w_tick) begin
      w_cnt_nxt  = '0;
      w_step_nxt = 1'b1;
      unique case (r_mode)
        M_BOUNCE: begin
          if (!r_dir) begin
            if (r_pattern[7]) begin
              w_dir_nxt  = 1'b1;
              w_pat_nxt  = w_rotr;
              w_wrap_nxt = 1'b1;
            end else begin
              w_pat_nxt = w_rotl;
            end
          end else begin
            if (r_pattern[0]) begin
              w_dir_nxt  = 1'b0;
              w_pat_nxt  = w_rotl;
              w_wrap_nxt = 1'b1;
            end else begin
              w_pat_nxt = w_rotr;
            end
          end
        end
        M_ROT_L: begin
          w_pat_nxt  = w_rotl;
          w_dir_nxt  = 1'b0;
          w_wrap_nxt = r_pattern[7];
        end
        M_ROT_R: begin
          w_pat_nxt  = w_rotr;
          w_dir_nxt  = 1'b1;
          w_wrap_nxt = r_pattern[0];
        end
        default: ;
      endcase
      // One-shot ends on the tick that completes a period; HOLD never completes one.
      if (r_oneshot && (((r_mode == M_BOUNCE) && (w_pat_nxt == 8'h01)) ||
                        (((r_mode == M_ROT_L) || (r_mode == M_ROT_R)) && w_wrap_nxt))) begin
        w_run_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    end else if (r_state == S_RUN) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_mode    <= M_BOUNCE;
      r_run     <= 1'b0;
      r_oneshot <= 1'b0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_pattern <= 8'h01;
      r_dir     <= 1'b0;
      r_step    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_run     <= w_run_nxt;
      r_oneshot <= w_oneshot_nxt;
      r_div     <= w_div_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pattern <= w_pat_nxt;
      r_dir     <= w_dir_nxt;
      r_step    <= w_step_nxt;
      r_wrap    <= w_wrap_nxt;
    end
  end

  assign pattern = r_pattern;
  assign dir     = r_dir;
  assign step    = r_step;
  assign wrap    = r_wrap;
  assign busy    = (r_state == S_RUN);

endmodule
